// File: rtl/add_stream.sv
// rtl/add_stream.sv - parametrised valid/ready streaming adder with bubble-collapsing pipeline
`timescale 1ns/1ps

module add_stream #(
   parameter int DW     = 9,
   parameter int STAGES = 2,
   parameter int SIGNED = 0,
   parameter int CNTW   = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic [DW-1:0]   data0,
   input  logic [DW-1:0]   data1,
   input  logic            valid,
   output logic            ready,
   output logic [DW:0]     out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [CNTW-1:0] out_cnt
);

   localparam int SW = DW + 1;

   // per-stage state: one valid bit and one data register per stage
   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] v_d;
   logic [SW-1:0]     data_q [STAGES];
   logic [SW-1:0]     data_d [STAGES];
   logic [CNTW-1:0]   cnt_q;
   logic [CNTW-1:0]   cnt_d;

   // stage enables; en[STAGES] is the downstream acceptance
   logic [STAGES:0]   en;
   logic [SW-1:0]     a_ext;
   logic [SW-1:0]     b_ext;
   logic [SW-1:0]     sum;
   logic              in_fire;
   logic              out_fire;

   // operand extension and full-precision sum (one extra bit, never overflows)
   always_comb begin
      a_ext = '0;
      b_ext = '0;
      if (SIGNED != 0) begin
         a_ext = {data0[DW-1], data0};
         b_ext = {data1[DW-1], data1};
      end else begin
         a_ext = {1'b0, data0};
         b_ext = {1'b0, data1};
      end
      sum = a_ext + b_ext;
   end

   // enable chain from the output back to stage 1: a stage may load when it is
   // empty or when everything after it will move, so bubbles collapse under stall
   always_comb begin
      logic chain;
      en    = '0;
      chain = out_ready;
      en[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         chain = !v_q[k] || chain;
         en[k] = chain;
      end
   end

   // handshake qualifiers; flush and reset both block new input
   always_comb begin
      ready    = en[0] && !flush && rst_n;
      in_fire  = valid && ready;
      out_fire = v_q[STAGES-1] && out_ready;
   end

   // next-state for the pipeline: data registers only load with a valid beat
   always_comb begin
      v_d    = v_q;
      data_d = data_q;
      if (en[0]) begin
         v_d[0] = in_fire;
         if (in_fire) begin
            data_d[0] = sum;
         end
      end
      for (int k = 1; k < STAGES; k++) begin
         if (en[k]) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1]) begin
               data_d[k] = data_q[k-1];
            end
         end
      end
      if (flush) begin
         v_d = '0;
      end
   end

   // completed output transfers; flush does not touch the counter
   always_comb begin
      cnt_d = cnt_q;
      if (out_fire) begin
         cnt_d = cnt_q + CNTW'(1);
      end
   end

   // state registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         cnt_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         v_q   <= v_d;
         cnt_q <= cnt_d;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   // outputs come straight from the last stage and the counter
   always_comb begin
      out_data  = data_q[STAGES-1];
      out_valid = v_q[STAGES-1];
      out_cnt   = cnt_q;
   end

endmodule

// File: tb/tb_add_stream.sv
// tb/tb_add_stream.sv - randomized and directed checks of add_stream against a queue model
`timescale 1ns/1ps

module tb_add_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rn;
   logic [8:0]  d0 [2];
   logic [8:0]  d1 [2];
   logic        vld [2];
   logic        ord [2];
   logic        fl [2];
   logic        rdy_o [2];
   logic        ov_o [2];
   logic [9:0]  od_o [2];
   logic [15:0] cnt_o [2];

   int errs = 0;
   int chks = 0;
   int cyc  = 0;

   typedef struct {
      logic [9:0] sum;
      int         vis;
   } item_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [9:0] ref_sum(input logic [8:0] a, input logic [8:0] b, input bit sg);
      int ea;
      int eb;
      ea = int'(a);
      eb = int'(b);
      if (sg) begin
         if (ea >= 256) ea -= 512;
         if (eb >= 256) eb -= 512;
      end
      return 10'((ea + eb) & 1023);
   endfunction

   always @(negedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int ST = (g == 0) ? 2 : 3;
      localparam int SG = (g == 0) ? 0 : 1;
      localparam int CW = (g == 0) ? 16 : 4;

      logic [CW-1:0] cnt;

      add_stream #(.DW(9), .STAGES(ST), .SIGNED(SG), .CNTW(CW)) u_dut (
         .clk       (clk),
         .rst_n     (rn),
         .flush     (fl[g]),
         .data0     (d0[g]),
         .data1     (d1[g]),
         .valid     (vld[g]),
         .ready     (rdy_o[g]),
         .out_data  (od_o[g]),
         .out_valid (ov_o[g]),
         .out_ready (ord[g]),
         .out_cnt   (cnt)
      );

      assign cnt_o[g] = 16'(cnt);

      item_t q[$];
      int    mcnt = 0;

      always @(negedge clk) begin : cmp
         bit exp_v;
         bit exp_r;
         bit in_hs;
         bit out_hs;
         if (!rn) begin
            check($sformatf("u%0d.rst_valid", g), ov_o[g], 0);
            check($sformatf("u%0d.rst_data", g), od_o[g], 0);
            check($sformatf("u%0d.rst_cnt", g), cnt_o[g], 0);
            check($sformatf("u%0d.rst_ready", g), rdy_o[g], 0);
            q.delete();
            mcnt = 0;
         end else begin
            exp_v = (q.size() > 0) && (cyc >= q[0].vis);
            exp_r = !fl[g] && ((q.size() < ST) || ord[g]);
            check($sformatf("u%0d.out_valid", g), ov_o[g], exp_v);
            if (exp_v) check($sformatf("u%0d.out_data", g), od_o[g], q[0].sum);
            check($sformatf("u%0d.ready", g), rdy_o[g], exp_r);
            check($sformatf("u%0d.out_cnt", g), cnt_o[g], mcnt % (1 << CW));
            out_hs = exp_v && ord[g];
            in_hs  = vld[g] && exp_r;
            if (out_hs) begin
               void'(q.pop_front());
               mcnt++;
               if (q.size() > 0 && q[0].vis < cyc + 1) q[0].vis = cyc + 1;
            end
            if (fl[g]) q.delete();
            if (in_hs) q.push_back('{sum: ref_sum(d0[g], d1[g], SG != 0), vis: cyc + ST});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int acc;
      int n;
      rn = 1'b0;
      for (int g = 0; g < 2; g++) begin
         d0[g] = '0; d1[g] = '0; vld[g] = 1'b0; ord[g] = 1'b0; fl[g] = 1'b0;
      end

      // reset values, then release
      repeat (2) tick();
      check("reset_valid", ov_o[0], 0);
      check("reset_data", od_o[0], 0);
      check("reset_cnt", cnt_o[0], 0);
      check("reset_ready", rdy_o[0], 0);
      rn = 1'b1;
      #1;
      check("release_ready", rdy_o[0], 1);

      // single max unsigned op: visible exactly 2 cycles after handshake
      d0[0] = 9'd511; d1[0] = 9'd511; vld[0] = 1'b1; ord[0] = 1'b1;
      tick();
      vld[0] = 1'b0;
      check("lat_early", ov_o[0], 0);
      tick();
      check("lat_exact", ov_o[0], 1);
      check("sum_1022", od_o[0], 10'd1022);
      tick();
      check("cnt_one", cnt_o[0], 1);

      // signed instance: -256 + -256, then -1 + 1
      d0[1] = 9'h100; d1[1] = 9'h100; vld[1] = 1'b1; ord[1] = 1'b1;
      tick();
      d0[1] = 9'h1FF; d1[1] = 9'd1;
      tick();
      vld[1] = 1'b0;
      tick();
      check("signed_neg512_v", ov_o[1], 1);
      check("signed_neg512", od_o[1], 10'h200);
      tick();
      check("signed_zero_v", ov_o[1], 1);
      check("signed_zero", od_o[1], 10'h000);

      // back-to-back stream (i, 2i)
      ord[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i < 8) begin
            d0[0] = 9'(i); d1[0] = 9'(2 * i); vld[0] = 1'b1;
         end else begin
            vld[0] = 1'b0;
         end
         if (i >= 2) begin
            check($sformatf("stream_v%0d", i - 2), ov_o[0], 1);
            check($sformatf("stream_d%0d", i - 2), od_o[0], 3 * (i - 2));
         end
         tick();
      end
      check("stream_cnt", cnt_o[0], 9);

      // capacity under backpressure
      ord[0] = 1'b0; acc = 0; n = 0;
      for (int i = 0; i < 6; i++) begin
         d0[0] = 9'(100 + n); d1[0] = 9'(n); vld[0] = 1'b1;
         #1;
         if (rdy_o[0]) begin
            acc++;
            n++;
         end
         tick();
      end
      check("cap_accepts", acc, 2);
      check("cap_ready_low", rdy_o[0], 0);
      check("cap_head", od_o[0], 10'd100);
      vld[0] = 1'b0; ord[0] = 1'b1;
      tick();
      check("drain_second", od_o[0], 10'd102);
      tick();
      check("drain_empty", ov_o[0], 0);
      check("drain_cnt", cnt_o[0], 11);

      // flush with ops in flight
      for (int i = 0; i < 3; i++) begin
         d0[0] = 9'(10 * i + 1); d1[0] = 9'd5; vld[0] = 1'b1;
         tick();
      end
      fl[0] = 1'b1; ord[0] = 1'b0;
      #1;
      check("flush_ready", rdy_o[0], 0);
      tick();
      fl[0] = 1'b0; vld[0] = 1'b0;
      check("flush_valid", ov_o[0], 0);
      check("flush_cnt", cnt_o[0], 12);
      d0[0] = 9'd7; d1[0] = 9'd8; vld[0] = 1'b1; ord[0] = 1'b1;
      tick();
      vld[0] = 1'b0;
      tick();
      check("post_flush_v", ov_o[0], 1);
      check("post_flush_d", od_o[0], 10'd15);
      tick();
      check("post_flush_cnt", cnt_o[0], 13);

      // asynchronous reset mid-stream
      ord[0] = 1'b0; d0[0] = 9'd3; d1[0] = 9'd4; vld[0] = 1'b1;
      tick();
      tick();
      vld[0] = 1'b0;
      tick();
      check("arst_pre_valid", ov_o[0], 1);
      #2;
      rn = 1'b0;
      #1;
      check("arst_valid", ov_o[0], 0);
      check("arst_data", od_o[0], 0);
      check("arst_cnt", cnt_o[0], 0);
      check("arst_ready", rdy_o[0], 0);
      @(posedge clk);
      #2;
      rn = 1'b1;
      #1;
      check("arst_release_ready", rdy_o[0], 1);

      // counter wrap on the 4-bit instance
      ord[1] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i < 16) begin
            d0[1] = 9'($urandom); d1[1] = 9'($urandom); vld[1] = 1'b1;
         end else begin
            vld[1] = 1'b0;
         end
         tick();
         if (i == 17) check("wrap_fifteen", cnt_o[1], 15);
      end
      check("wrap_zero", cnt_o[1], 0);

      // randomized traffic on both instances
      for (int k = 0; k < 3000; k++) begin
         for (int g = 0; g < 2; g++) begin
            d0[g]  = 9'($urandom);
            d1[g]  = 9'($urandom);
            vld[g] = ($urandom % 4) != 0;
            ord[g] = ($urandom % 3) != 0;
            fl[g]  = ($urandom % 64) == 0;
         end
         tick();
      end
      for (int g = 0; g < 2; g++) begin
         vld[g] = 1'b0; fl[g] = 1'b0; ord[g] = 1'b1;
      end
      repeat (8) tick();
      check("final_empty0", ov_o[0], 0);
      check("final_empty1", ov_o[1], 0);

      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end

endmodule
